sram_arbiter: RTL

Arbitrates the single SDRAM byte port of the PET2001 top level between three requesters:
- ROM/TAP download writes from the MiST I/O block;
- tape playback reads;
- an auxiliary read/write port reserved for RAM expansion.

Download writes arrive as bare strobes, so they are posted into a small FIFO. Tape and aux requests use a level-request / pulse-acknowledge handshake. The block sits between those clients and the `sram` controller, which then has exactly one master.

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/sram_arb_fifo.sv | 71 +++++++
 rtl/sram_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types for the SDRAM byte-port arbiter.
// FSM state and source-select enums, plus the download FIFO entry layout.
package sram_arb_pkg;

   // Address width of a download FIFO entry; the arbiter's AW must match.
   localparam int ARB_AW = 25;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      SRC_DL   = 2'd0,
      SRC_TAPE = 2'd1,
      SRC_AUX  = 2'd2
   } arb_src_t;

   typedef struct packed {
      logic [ARB_AW-1:0] addr;
      logic [7:0]        data;
   } dl_entry_t;

endpackage

// File: rtl/sram_arb_fifo.sv
// sram_arb_fifo: synchronous FIFO with registered full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module sram_arb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 33
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;
   logic          r_full;
   logic          r_empty;

   logic          w_do_pop;
   logic          w_do_push;
   logic [PW:0]   w_next_count;

   assign w_do_pop  = pop && !r_empty;
   assign w_do_push = push && (!r_full || w_do_pop);

   // Next occupancy: simultaneous push and pop leaves the count unchanged.
   always_comb begin
      w_next_count = r_count;
      if (w_do_push && !w_do_pop)
         w_next_count = r_count + 1'b1;
      else if (!w_do_push && w_do_pop)
         w_next_count = r_count - 1'b1;
   end

   // Pointer, count and flag registers; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= w_next_count;
         r_full  <= (w_next_count == FULL_CNT);
         r_empty <= (w_next_count == '0);
      end
   end

   // Entry storage; contents are meaningless while empty, so no reset.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= din;
   end

   assign dout  = r_mem[r_rptr];
   assign full  = r_full;
   assign empty = r_empty;
   assign count = r_count;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: single-master front end for the SDRAM byte port.
// Download writes are posted through a FIFO; tape and aux use req/ack.
// Optional WAIT watchdog and mem_err output: define SRAM_ARB_TIMEOUT_EN.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW         = ARB_AW,
   parameter int DL_DEPTH   = 4,
   parameter int STARVE_MAX = 8
`ifdef SRAM_ARB_TIMEOUT_EN
  ,parameter int TIMEOUT    = 255
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dl_wr,
   input  logic [AW-1:0] dl_addr,
   input  logic [7:0]    dl_data,
   output logic          dl_full,
   output logic          dl_ovf,
   input  logic          tape_req,
   input  logic [AW-1:0] tape_addr,
   output logic          tape_ack,
   output logic [7:0]    tape_data,
   input  logic          aux_req,
   input  logic          aux_we,
   input  logic [AW-1:0] aux_addr,
   input  logic [7:0]    aux_wdata,
   output logic          aux_ack,
   output logic [7:0]    aux_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_we,
   output logic          mem_rd,
   input  logic [7:0]    mem_dout,
   input  logic          mem_done,
   output logic          busy
`ifdef SRAM_ARB_TIMEOUT_EN
  ,output logic          mem_err
`endif
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0]  r_wd;
   logic           r_mem_err;
`endif

   arb_state_t     r_state;
   arb_src_t       r_src;
   logic [SW-1:0]  r_starve;
   logic           r_aux_we;
   logic [AW-1:0]  r_mem_addr;
   logic [7:0]     r_mem_din;
   logic           r_mem_we;
   logic           r_mem_rd;
   logic           r_tape_ack;
   logic [7:0]     r_tape_data;
   logic           r_aux_ack;
   logic [7:0]     r_aux_rdata;
   logic           r_dl_ovf;

   dl_entry_t                    w_push_entry;
   dl_entry_t                    w_head;
   logic                         w_full;
   logic                         w_empty;
   logic                         w_pop;
   logic                         w_tape_starved;
   logic [$clog2(DL_DEPTH):0]    w_count;

   assign w_push_entry   = '{addr: dl_addr, data: dl_data};
   assign w_pop          = (r_state == ST_ISSUE) && (r_src == SRC_DL);
   assign w_tape_starved = tape_req && (r_starve == STARVE_LIM);

   sram_arb_fifo #(
      .DEPTH (DL_DEPTH),
      .W     ($bits(dl_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (dl_wr),
      .pop   (w_pop),
      .din   (w_push_entry),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Arbitration FSM: grant in IDLE, strobe in ISSUE, collect completion in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_src       <= SRC_DL;
         r_starve    <= '0;
         r_aux_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
         r_mem_we    <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_tape_ack  <= 1'b0;
         r_tape_data <= '0;
         r_aux_ack   <= 1'b0;
         r_aux_rdata <= '0;
         r_dl_ovf    <= 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
         r_wd        <= '0;
         r_mem_err   <= 1'b0;
`endif
      end else begin
         r_tape_ack <= 1'b0;
         r_aux_ack  <= 1'b0;
         // A strobe is lost only when full with no pop freeing a slot.
         if (dl_wr && w_full && !w_pop) r_dl_ovf <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (!tape_req) r_starve <= '0;
               if (!w_empty && !w_tape_starved) begin
                  r_src      <= SRC_DL;
                  r_mem_addr <= w_head.addr;
                  r_mem_din  <= w_head.data;
                  r_mem_we   <= 1'b1;
                  r_state    <= ST_ISSUE;
                  if (tape_req) r_starve <= r_starve + 1'b1;
               end else if (tape_req) begin
                  r_src      <= SRC_TAPE;
                  r_mem_addr <= tape_addr;
                  r_mem_din  <= '0;
                  r_mem_rd   <= 1'b1;
                  r_starve   <= '0;
                  r_state    <= ST_ISSUE;
               end else if (aux_req) begin
                  r_src      <= SRC_AUX;
                  r_aux_we   <= aux_we;
                  r_mem_addr <= aux_addr;
                  r_mem_din  <= aux_wdata;
                  r_mem_we   <= aux_we;
                  r_mem_rd   <= !aux_we;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_mem_we <= 1'b0;
               r_mem_rd <= 1'b0;
               r_state  <= ST_WAIT;
`ifdef SRAM_ARB_TIMEOUT_EN
               r_wd     <= '0;
`endif
            end
            ST_WAIT: begin
               if (mem_done) begin
                  r_state <= ST_IDLE;
                  if (r_src == SRC_TAPE) begin
                     r_tape_data <= mem_dout;
                     r_tape_ack  <= 1'b1;
                  end else if (r_src == SRC_AUX) begin
                     if (!r_aux_we) r_aux_rdata <= mem_dout;
                     r_aux_ack <= 1'b1;
                  end
               end
`ifdef SRAM_ARB_TIMEOUT_EN
               else if (r_wd == WD_LAST) begin
                  // Memory never answered: release the requester with an all-ones byte.
                  r_state   <= ST_IDLE;
                  r_mem_err <= 1'b1;
                  if (r_src == SRC_TAPE) begin
                     r_tape_data <= 8'hFF;
                     r_tape_ack  <= 1'b1;
                  end else if (r_src == SRC_AUX) begin
                     r_aux_rdata <= 8'hFF;
                     r_aux_ack   <= 1'b1;
                  end
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dl_full   = w_full;
   assign dl_ovf    = r_dl_ovf;
   assign tape_ack  = r_tape_ack;
   assign tape_data = r_tape_data;
   assign aux_ack   = r_aux_ack;
   assign aux_rdata = r_aux_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_din   = r_mem_din;
   assign mem_we    = r_mem_we;
   assign mem_rd    = r_mem_rd;
   assign busy      = (r_state != ST_IDLE) || (w_count != '0);
`ifdef SRAM_ARB_TIMEOUT_EN
   assign mem_err   = r_mem_err;
`endif

endmodule
